// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the pipeline-to-memory arbitration path.
//   - Default address/data widths.
//   - Arbiter state encoding: which requester owns the access issued last cycle.
//   - Owner constants used to steer the SRAM request mux.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_RESP_INST = 2'd1,
    ARB_RESP_DATA = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles in which the instruction requester
// asked for the SRAM but was denied. Once the count reaches STARVE_MAX while a
// request is pending, starve_hit tells the arbiter to let the fetch side win.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   inst_req     : instruction request pending this cycle
//   inst_grant   : instruction request granted this cycle
//   starve_hit   : fetch side must win this cycle
module arb_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_grant,
  output logic starve_hit
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!inst_req || inst_grant) begin
      cnt_d = '0;
    end else if (cnt_q != 4'(STARVE_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Depends only on the registered count, so there is no loop through the
  // grant logic that consumes it.
  assign starve_hit = inst_req && (cnt_q == 4'(STARVE_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between instruction fetch and the
// data (load/store) stage. One access issues per cycle; its response returns
// the next cycle. Data wins by default; the starvation counter forces a fetch
// grant after STARVE_MAX consecutive denials.
// Ports:
//   clk, resetn                       : clock, asynchronous active-low reset
//   inst_req/addr/flush               : fetch request, address, cancel
//   inst_addr_ok/data_ok/rdata        : fetch accept (comb), response, word
//   data_req/wr/wstrb/addr/wdata      : load/store request
//   data_addr_ok/data_ok/rdata        : data accept (comb), response, word
//   ram_en/wen/addr/wdata, ram_rdata  : SRAM port (read data one cycle later)
module sram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                inst_flush,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  arb_state_e state_q, state_d;
  logic       flush_q, flush_d;
  logic       starve_hit;
  logic       grant_data;
  logic       grant_inst;
  logic       owner;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_grant (grant_inst),
    .starve_hit (starve_hit)
  );

  // Grant and SRAM request mux. Gating with resetn keeps the SRAM idle and
  // both accepts low for the whole time reset is asserted.
  always_comb begin
    grant_data = resetn && data_req && !starve_hit;
    grant_inst = resetn && inst_req && !grant_data;
    owner      = grant_data ? OWN_DATA : OWN_INST;

    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    ram_en       = grant_data || grant_inst;
    ram_addr     = (owner == OWN_DATA) ? data_addr : inst_addr;
    ram_wdata    = data_wdata;
    ram_wen      = (grant_data && data_wr) ? data_wstrb : '0;
  end

  // Next state records the owner of the access issued this cycle.
  always_comb begin
    state_d = ARB_IDLE;
    if (grant_data) begin
      state_d = ARB_RESP_DATA;
    end else if (grant_inst) begin
      state_d = ARB_RESP_INST;
    end
    flush_d = grant_inst && inst_flush;
  end

  // Response demux: the registered state says who the returning word belongs
  // to; a fetch response is dropped if it was cancelled at issue (flush_q) or
  // is being cancelled now (inst_flush).
  always_comb begin
    inst_data_ok = (state_q == ARB_RESP_INST) && !flush_q && !inst_flush;
    data_data_ok = (state_q == ARB_RESP_DATA);
    inst_rdata   = ram_rdata;
    data_rdata   = ram_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_flush, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SM)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_flush   (inst_flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Synchronous single-port SRAM the DUT drives.
  logic [31:0] sram_mem [logic [29:0]];
  // Reference view of memory contents, updated at the moment a store is accepted.
  logic [31:0] ref_mem  [logic [29:0]];

  function automatic logic [31:0] dflt(input logic [29:0] k);
    return {k, 2'b01} ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      logic [31:0] w;
      w = sram_mem.exists(ram_addr[31:2]) ? sram_mem[ram_addr[31:2]] : dflt(ram_addr[31:2]);
      ram_rdata <= w;
      for (int b = 0; b < 4; b++) if (ram_wen[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      sram_mem[ram_addr[31:2]] = w;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a[31:2]);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sram_mem[a[31:2]] = v;
    ref_mem[a[31:2]]  = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: starvation count and the one response in flight.
  int unsigned m_starve = 0;
  logic        p_valid = 1'b0, p_owner_data = 1'b0, p_load = 1'b0, p_flush = 1'b0;
  logic [31:0] p_rdata = '0;

  // Last observed values, for directed checks made after a cycle.
  logic        obs_ignt, obs_dgnt, obs_iok, obs_dok;
  logic [31:0] obs_irdata, obs_drdata;

  task automatic do_cycle(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                          input logic dreq, input logic dwr, input logic [3:0] dstrb,
                          input logic [31:0] daddr, input logic [31:0] dwdata);
    logic eg_d, eg_i, e_iok, e_dok;
    logic [31:0] w;
    @(negedge clk);
    inst_req = ireq; inst_addr = iaddr; inst_flush = iflush;
    data_req = dreq; data_wr = dwr; data_wstrb = dstrb; data_addr = daddr; data_wdata = dwdata;
    #1;
    eg_d = dreq && !(ireq && m_starve == SM);
    eg_i = ireq && !eg_d;
    chk("inst_addr_ok", inst_addr_ok, eg_i);
    chk("data_addr_ok", data_addr_ok, eg_d);
    chk("ram_en", ram_en, eg_d || eg_i);
    chk("ram_wen", ram_wen, (eg_d && dwr) ? dstrb : 4'h0);
    if (eg_d) chk("ram_addr_d", ram_addr, daddr);
    if (eg_i) chk("ram_addr_i", ram_addr, iaddr);
    if (eg_d && dwr) chk("ram_wdata", ram_wdata, dwdata);
    e_iok = p_valid && !p_owner_data && !p_flush && !iflush;
    e_dok = p_valid && p_owner_data;
    chk("inst_data_ok", inst_data_ok, e_iok);
    if (e_iok) chk("inst_rdata", inst_rdata, p_rdata);
    chk("data_data_ok", data_data_ok, e_dok);
    if (e_dok && p_load) chk("data_rdata", data_rdata, p_rdata);
    obs_ignt = inst_addr_ok; obs_dgnt = data_addr_ok;
    obs_iok = inst_data_ok; obs_dok = data_data_ok;
    obs_irdata = inst_rdata; obs_drdata = data_rdata;
    // Advance the model by one issue slot.
    p_valid = eg_d || eg_i;
    p_owner_data = eg_d;
    p_load = eg_d && !dwr;
    p_flush = eg_i && iflush;
    p_rdata = eg_d ? ref_rd(daddr) : ref_rd(iaddr);
    if (eg_d && dwr) begin
      w = ref_rd(daddr);
      for (int b = 0; b < 4; b++) if (dstrb[b]) w[8*b +: 8] = dwdata[8*b +: 8];
      ref_mem[daddr[31:2]] = w;
    end
    if (ireq && !eg_i) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else               m_starve = 0;
    @(posedge clk);
  endtask

  task automatic idle(input logic iflush);
    do_cycle(1'b0, '0, iflush, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  logic [9:0]  pat;
  logic        hi_req, hd_req, hd_wr;
  logic [31:0] hi_addr, hd_addr, hd_wdata;
  logic [3:0]  hd_strb;

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = '0; inst_flush = 0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    preload(32'hBFC0_0000, 32'h3C01_1234);
    // Reset state with requests pending: nothing may be accepted.
    #2;
    inst_req = 1; data_req = 1;
    #1;
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_wen", ram_wen, 4'h0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_data_data_ok", data_data_ok, 1'b0);
    inst_req = 0; data_req = 0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk);

    // Single fetch.
    do_cycle(1, 32'hBFC0_0000, 0, 0, 0, 4'h0, '0, '0);
    chk("single_ignt", obs_ignt, 1'b1);
    idle(0);
    chk("single_iok", obs_iok, 1'b1);
    chk("single_irdata", obs_irdata, 32'h3C01_1234);

    // Store, load, byte store, load.
    do_cycle(0, '0, 0, 1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    do_cycle(0, '0, 0, 1, 0, 4'h0, 32'h100, '0);
    chk("store_dok", obs_dok, 1'b1);
    do_cycle(0, '0, 0, 1, 1, 4'h2, 32'h100, 32'h0000_AA00);
    chk("load_drdata", obs_drdata, 32'hDEAD_BEEF);
    do_cycle(0, '0, 0, 1, 0, 4'h0, 32'h100, '0);
    idle(0);
    chk("bytestore_drdata", obs_drdata, 32'hDEAD_AAEF);

    // Contention: both requesting continuously.
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 32'hBFC0_0000, 0, 1, 0, 4'h0, 32'h100, '0);
      chk("contention_ignt", obs_ignt, pat[i]);
    end
    idle(0);

    // Flush at issue.
    do_cycle(1, 32'hBFC0_0000, 1, 0, 0, 4'h0, '0, '0);
    idle(0);
    chk("flush_issue_iok", obs_iok, 1'b0);
    // Flush during the response, concurrent with a data issue and its response.
    do_cycle(1, 32'hBFC0_0000, 0, 0, 0, 4'h0, '0, '0);
    do_cycle(0, '0, 1, 1, 0, 4'h0, 32'h100, '0);
    chk("flush_resp_iok", obs_iok, 1'b0);
    idle(1);
    chk("flush_data_dok", obs_dok, 1'b1);

    // Back-to-back D, I, D.
    do_cycle(0, '0, 0, 1, 0, 4'h0, 32'h100, '0);
    do_cycle(1, 32'hBFC0_0000, 0, 0, 0, 4'h0, '0, '0);
    chk("b2b_dok1", obs_dok, 1'b1);
    do_cycle(0, '0, 0, 1, 0, 4'h0, 32'h104, '0);
    chk("b2b_iok", obs_iok, 1'b1);
    idle(0);
    chk("b2b_dok2", obs_dok, 1'b1);

    // Reset half a cycle after a load grant.
    do_cycle(0, '0, 0, 1, 0, 4'h0, 32'h100, '0);
    #5 resetn = 1'b0;
    #1;
    chk("midrst_ram_en", ram_en, 1'b0);
    chk("midrst_data_addr_ok", data_addr_ok, 1'b0);
    chk("midrst_data_data_ok", data_data_ok, 1'b0);
    @(posedge clk); #1;
    chk("midrst_data_data_ok2", data_data_ok, 1'b0);
    @(negedge clk);
    data_req = 0; resetn = 1'b1;
    #1;
    chk("midrst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("midrst_starve", 32'(dut.u_starve.cnt_q), 32'd0);
    p_valid = 1'b0; m_starve = 0;
    @(posedge clk);
    idle(0);
    chk("midrst_no_dok", obs_dok, 1'b0);

    // Randomized traffic against the reference model.
    hi_req = 0; hd_req = 0; hd_wr = 0; hi_addr = '0; hd_addr = '0; hd_wdata = '0; hd_strb = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hi_req) begin
        hi_req  = ($urandom_range(9) < 7);
        hi_addr = 32'h100 + 32'($urandom_range(7)) * 4;
      end
      if (!hd_req) begin
        hd_req   = ($urandom_range(9) < 6);
        hd_wr    = $urandom_range(1) == 1;
        hd_strb  = 4'($urandom_range(15));
        hd_addr  = 32'h100 + 32'($urandom_range(7)) * 4;
        hd_wdata = $urandom;
      end
      do_cycle(hi_req, hi_addr, $urandom_range(4) == 0, hd_req, hd_wr, hd_strb, hd_addr, hd_wdata);
      if (obs_ignt) hi_req = 0;
      if (obs_dgnt) hd_req = 0;
    end
    idle(0);
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
